// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the PE partial-sum stage: FSM encoding and saturation bounds.
package psum_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCUM     = 2'd1,
      WAIT_XFER = 2'd2
   } state_t;

   // Bounds are returned 64 bits wide; callers cast down to their accumulator width.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w);
      return ~sat_max(w);
   endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Product stream, control and column shift-chain signals of one partial-sum stage.
// Handshake: a product is taken on a rising edge when i_valid is high and o_stall is low;
// while o_stall is high upstream keeps i_prod/i_last stable and the stage ignores i_valid.
interface psum_accumulator_if #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24
);
   logic                     i_valid;
   logic signed [PROD_W-1:0] i_prod;
   logic                     i_last;
   logic                     i_clear;
   logic                     i_shift;
   logic [ACC_W-1:0]         i_chain_in;
   logic [ACC_W-1:0]         o_chain_out;
   logic                     o_shadow_full;
   logic                     o_stall;
   logic                     o_acc_ovf;
   logic [1:0]               o_dbg_state;
   logic [ACC_W-1:0]         o_dbg_acc;

   modport master (
      output i_valid, i_prod, i_last, i_clear, i_shift, i_chain_in,
      input  o_chain_out, o_shadow_full, o_stall, o_acc_ovf, o_dbg_state, o_dbg_acc
   );

   modport slave (
      input  i_valid, i_prod, i_last, i_clear, i_shift, i_chain_in,
      output o_chain_out, o_shadow_full, o_stall, o_acc_ovf, o_dbg_state, o_dbg_acc
   );
endinterface

// File: rtl/Adder_truah.sv
// Truncated approximate adder: the IGNORE_BIT LSBs of both operands are zeroed before the add.
module Adder_truah #(
   parameter int WIDTH_A    = 24,
   parameter int WIDTH_B    = 24,
   parameter int IGNORE_BIT = 0
) (
   input  logic [WIDTH_A-1:0] a,
   input  logic [WIDTH_B-1:0] b,
   output logic [WIDTH_A-1:0] sum
);
   localparam logic [WIDTH_A-1:0] MASK_A = {WIDTH_A{1'b1}} << IGNORE_BIT;
   localparam logic [WIDTH_B-1:0] MASK_B = {WIDTH_B{1'b1}} << IGNORE_BIT;

   logic [WIDTH_B-1:0] b_m;
   logic [WIDTH_A-1:0] b_ext;

   assign b_m   = b & MASK_B;
   // b is sign-extended when narrower than a; the sum wraps at WIDTH_A.
   assign b_ext = WIDTH_A'($signed(b_m));
   assign sum   = (a & MASK_A) + b_ext;
endmodule

// File: rtl/psum_accumulator.sv
// PE partial-sum accumulator with a shadow register on the column shift chain.
// Build option PSUM_ACC_SAT_EN: saturate on signed overflow instead of wrapping.
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int PROD_W     = 16,
   parameter int ACC_W      = 24,
   parameter int IGNORE_BIT = 0
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   psum_accumulator_if.slave bus
);
   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] shadow_q;
   logic             full_q;

   logic [ACC_W-1:0] ext;
   logic [ACC_W-1:0] add_raw;
   logic [ACC_W-1:0] next;
   logic             add_ovf;
   logic             stall;
   logic             accept;
   logic             xfer_req;
   logic             xfer_ok;
   logic [ACC_W-1:0] xfer_val;

   assign ext = ACC_W'($signed(bus.i_prod));

   Adder_truah #(
      .WIDTH_A    (ACC_W),
      .WIDTH_B    (ACC_W),
      .IGNORE_BIT (IGNORE_BIT)
   ) u_adder (
      .a   (acc_q),
      .b   (ext),
      .sum (add_raw)
   );

   assign add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (add_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef PSUM_ACC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

   // Both operands share the sign on overflow, so the accumulator sign picks the rail.
   assign next = !add_ovf ? add_raw : (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
   assign next = add_raw;
`endif

   assign stall  = (state_q == WAIT_XFER);
   assign accept = bus.i_valid && !stall;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      xfer_req = 1'b0;
      xfer_val = acc_q;
      xfer_ok  = 1'b0;

      unique case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               if (add_ovf) ovf_d = 1'b1;
               if (bus.i_last) begin
                  xfer_req = 1'b1;
                  xfer_val = next;
               end else begin
                  acc_d   = next;
                  state_d = ACCUM;
               end
            end
         end
         WAIT_XFER: xfer_req = 1'b1;
         default:   state_d  = IDLE;
      endcase

      // A shift in the same cycle blocks the transfer; the value is parked in acc.
      if (xfer_req) begin
         if (!full_q && !bus.i_shift) begin
            xfer_ok = 1'b1;
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
         end else begin
            acc_d   = xfer_val;
            state_d = WAIT_XFER;
         end
      end

      if (bus.i_clear) begin
         xfer_ok = 1'b0;
         acc_d   = '0;
         ovf_d   = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         shadow_q <= '0;
         full_q   <= 1'b0;
      end else if (bus.i_shift) begin
         shadow_q <= bus.i_chain_in;
         full_q   <= 1'b0;
      end else if (xfer_ok) begin
         shadow_q <= xfer_val;
         full_q   <= 1'b1;
      end
   end

   assign bus.o_chain_out   = shadow_q;
   assign bus.o_shadow_full = full_q;
   assign bus.o_stall       = stall;
   assign bus.o_acc_ovf     = ovf_q;
   assign bus.o_dbg_state   = state_q;
   assign bus.o_dbg_acc     = acc_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: three instances cover the default, truncated and 8-bit builds.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  psum_accumulator_if #(.PROD_W(16), .ACC_W(24)) ifa ();
  psum_accumulator_if #(.PROD_W(16), .ACC_W(24)) ifb ();
  psum_accumulator_if #(.PROD_W(8),  .ACC_W(8))  ifc ();

  psum_accumulator #(.PROD_W(16), .ACC_W(24), .IGNORE_BIT(0)) dut_a (.i_clk(clk), .i_rstn(rstn), .bus(ifa));
  psum_accumulator #(.PROD_W(16), .ACC_W(24), .IGNORE_BIT(2)) dut_b (.i_clk(clk), .i_rstn(rstn), .bus(ifb));
  psum_accumulator #(.PROD_W(8),  .ACC_W(8),  .IGNORE_BIT(0)) dut_c (.i_clk(clk), .i_rstn(rstn), .bus(ifc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] p, input logic l);
    ifa.i_valid = 1'b1;
    ifa.i_prod  = p;
    ifa.i_last  = l;
    tick();
    ifa.i_valid = 1'b0;
    ifa.i_last  = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] p, input logic l);
    ifb.i_valid = 1'b1;
    ifb.i_prod  = p;
    ifb.i_last  = l;
    tick();
    ifb.i_valid = 1'b0;
    ifb.i_last  = 1'b0;
  endtask

  task automatic push_c(input logic [7:0] p, input logic l);
    ifc.i_valid = 1'b1;
    ifc.i_prod  = p;
    ifc.i_last  = l;
    tick();
    ifc.i_valid = 1'b0;
    ifc.i_last  = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    ifa.i_valid = 0; ifa.i_prod = '0; ifa.i_last = 0; ifa.i_clear = 0; ifa.i_shift = 0; ifa.i_chain_in = '0;
    ifb.i_valid = 0; ifb.i_prod = '0; ifb.i_last = 0; ifb.i_clear = 0; ifb.i_shift = 0; ifb.i_chain_in = '0;
    ifc.i_valid = 0; ifc.i_prod = '0; ifc.i_last = 0; ifc.i_clear = 0; ifc.i_shift = 0; ifc.i_chain_in = '0;

    // reset values
    #12;
    check("rst_chain", ifa.o_chain_out, 0);
    check("rst_full",  ifa.o_shadow_full, 0);
    check("rst_stall", ifa.o_stall, 0);
    check("rst_ovf",   ifa.o_acc_ovf, 0);
    check("rst_state", ifa.o_dbg_state, IDLE);
    check("rst_acc",   ifa.o_dbg_acc, 0);
    #10 rstn = 1'b1;

    // 3 + -5 + 10 = 8 into an empty shadow
    push_a(16'd3, 1'b0);
    check("acc_3", ifa.o_dbg_acc, 24'd3);
    check("state_accum", ifa.o_dbg_state, ACCUM);
    push_a(-16'sd5, 1'b0);
    check("acc_neg2", ifa.o_dbg_acc, 24'hFFFFFE);
    push_a(16'd10, 1'b1);
    check("ctx1_chain", ifa.o_chain_out, 24'd8);
    check("ctx1_full",  ifa.o_shadow_full, 1);
    check("ctx1_acc0",  ifa.o_dbg_acc, 0);
    check("ctx1_idle",  ifa.o_dbg_state, IDLE);
    check("ctx1_stall", ifa.o_stall, 0);

    // shadow full: last is blocked and parked (20 + 22 = 42)
    push_a(16'd20, 1'b0);
    push_a(16'd22, 1'b1);
    check("blk_stall", ifa.o_stall, 1);
    check("blk_state", ifa.o_dbg_state, WAIT_XFER);
    check("blk_acc",   ifa.o_dbg_acc, 24'd42);
    check("blk_chain", ifa.o_chain_out, 24'd8);

    // valid product while stalled must be ignored
    ifa.i_valid = 1'b1; ifa.i_prod = 16'd99; ifa.i_last = 1'b1;
    tick();
    ifa.i_valid = 1'b0; ifa.i_last = 1'b0;
    check("ign_acc",   ifa.o_dbg_acc, 24'd42);
    check("ign_stall", ifa.o_stall, 1);

    // shift wins over the pending transfer
    ifa.i_shift = 1'b1; ifa.i_chain_in = 24'h55;
    tick();
    ifa.i_shift = 1'b0; ifa.i_chain_in = 24'h77;
    #1;
    check("sh_chain", ifa.o_chain_out, 24'h55);
    check("sh_full",  ifa.o_shadow_full, 0);
    check("sh_stall", ifa.o_stall, 1);
    tick();
    check("retry_chain", ifa.o_chain_out, 24'd42);
    check("retry_full",  ifa.o_shadow_full, 1);
    check("retry_stall", ifa.o_stall, 0);
    check("retry_idle",  ifa.o_dbg_state, IDLE);

    // clear drops the product and the partial sum, shadow untouched
    push_a(16'd4, 1'b0);
    check("clr_pre_acc", ifa.o_dbg_acc, 24'd4);
    ifa.i_valid = 1'b1; ifa.i_prod = 16'd9; ifa.i_clear = 1'b1;
    tick();
    ifa.i_valid = 1'b0; ifa.i_clear = 1'b0;
    check("clr_acc",   ifa.o_dbg_acc, 0);
    check("clr_state", ifa.o_dbg_state, IDLE);
    check("clr_chain", ifa.o_chain_out, 24'd42);
    check("clr_full",  ifa.o_shadow_full, 1);

    // back-to-back contexts with a shift overlapping the next context
    ifa.i_shift = 1'b1; ifa.i_chain_in = 24'h0;
    tick();
    ifa.i_shift = 1'b0;
    check("b2b_empty", ifa.o_shadow_full, 0);
    push_a(16'd5, 1'b1);
    check("b2b_chain5", ifa.o_chain_out, 24'd5);
    ifa.i_valid = 1'b1; ifa.i_prod = 16'd6; ifa.i_last = 1'b0;
    ifa.i_shift = 1'b1; ifa.i_chain_in = 24'h11;
    tick();
    ifa.i_valid = 1'b0; ifa.i_shift = 1'b0;
    check("b2b_acc6",  ifa.o_dbg_acc, 24'd6);
    check("b2b_chain", ifa.o_chain_out, 24'h11);
    check("b2b_stall", ifa.o_stall, 0);
    push_a(16'd1, 1'b1);
    check("b2b_chain7", ifa.o_chain_out, 24'd7);
    check("b2b_full",   ifa.o_shadow_full, 1);

    // asynchronous reset while waiting to transfer
    push_a(16'd2, 1'b1);
    check("wr_stall", ifa.o_stall, 1);
    #3 rstn = 1'b0;
    #1;
    check("ar_chain", ifa.o_chain_out, 0);
    check("ar_full",  ifa.o_shadow_full, 0);
    check("ar_stall", ifa.o_stall, 0);
    check("ar_state", ifa.o_dbg_state, IDLE);
    check("ar_acc",   ifa.o_dbg_acc, 0);
    #2 rstn = 1'b1;
    push_a(16'd3, 1'b1);
    check("post_rst_chain", ifa.o_chain_out, 24'd3);
    check("post_rst_full",  ifa.o_shadow_full, 1);

    // truncated adder, two LSBs ignored: (7->4) then 4 + (6->4) = 8
    push_b(16'd7, 1'b0);
    check("tr_acc4", ifb.o_dbg_acc, 24'd4);
    push_b(16'd6, 1'b1);
    check("tr_chain", ifb.o_chain_out, 24'd8);

    // 8-bit overflow: 100 + 100
    push_c(8'd100, 1'b0);
    check("ov_acc100", ifc.o_dbg_acc, 8'd100);
    check("ov_flag0",  ifc.o_acc_ovf, 0);
    push_c(8'd100, 1'b0);
`ifdef PSUM_ACC_SAT_EN
    check("ov_acc", ifc.o_dbg_acc, 8'h7F);
`else
    check("ov_acc", ifc.o_dbg_acc, 8'hC8);
`endif
    check("ov_flag1", ifc.o_acc_ovf, 1);
    push_c(8'd0, 1'b1);
`ifdef PSUM_ACC_SAT_EN
    check("ov_chain", ifc.o_chain_out, 8'h7F);
`else
    check("ov_chain", ifc.o_chain_out, 8'hC8);
`endif
    check("ov_flag_cleared", ifc.o_acc_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
